// File: rtl/traffic_light_monitor.sv
// Conflict, sequence, timing and liveness monitor for a four-approach lamp bus.
// Latches the first fault, and drives a flash command while that fault stays latched.
// Defining MONITOR_STATS_EN adds the cycle_count and fault_count statistics outputs.
module traffic_light_monitor #(
    parameter int MIN_YELLOW = 4,
    parameter int WATCHDOG   = 16,
    parameter int FLASH_DIV  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  lightM1,
    input  logic [2:0]  lightM2,
    input  logic [2:0]  lightM3,
    input  logic [2:0]  lightM4,
    input  logic        clear_fault,
    output logic        fault,
    output logic [2:0]  fault_code,
`ifdef MONITOR_STATS_EN
    output logic        flash,
    output logic [15:0] cycle_count,
    output logic [7:0]  fault_count
`else
    output logic        flash
`endif
);

    localparam logic [2:0]  RED     = 3'b100;
    localparam logic [2:0]  YELLOW  = 3'b010;
    localparam logic [2:0]  GREEN   = 3'b001;
    localparam logic [11:0] ALL_RED = {RED, RED, RED, RED};
    localparam logic [7:0]  MIN_Y_C = 8'(MIN_YELLOW);
    localparam logic [7:0]  WD_C    = 8'(WATCHDOG);
    localparam logic [7:0]  FD_LAST = 8'(FLASH_DIV - 1);

    function automatic logic code_valid(input logic [2:0] c);
        case (c)
            RED, YELLOW, GREEN: code_valid = 1'b1;
            default:            code_valid = 1'b0;
        endcase
    endfunction

    function automatic logic step_legal(input logic [2:0] p, input logic [2:0] c);
        step_legal = (p == c) || (p == GREEN && c == YELLOW) ||
                     (p == YELLOW && c == RED) || (p == RED && c == GREEN);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [11:0] prev_q, prev_d;
    logic        primed_q, primed_d;
    logic        fault_q, fault_d;
    logic [2:0]  code_q, code_d;
    logic        flash_q, flash_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  dwell_a_q, dwell_a_d;
    logic [7:0]  dwell_b_q, dwell_b_d;
    logic [7:0]  unch_q, unch_d;

    logic [11:0] now_s;
    logic        invalid_s, conflict_s, pair_s, seq_s, short_s, stuck_s, latch_s;
    logic [2:0]  cause_s;

    // Fault condition decode and priority selection for the current sample
    always_comb begin
        now_s      = {lightM4, lightM3, lightM2, lightM1};
        invalid_s  = ~(code_valid(lightM1) & code_valid(lightM2) &
                       code_valid(lightM3) & code_valid(lightM4));
        conflict_s = (lightM1 != RED || lightM3 != RED) && (lightM2 != RED || lightM4 != RED);
        pair_s     = (lightM1 != lightM3) || (lightM2 != lightM4);
        seq_s      = ~(step_legal(prev_q[2:0], lightM1) & step_legal(prev_q[5:3], lightM2) &
                       step_legal(prev_q[8:6], lightM3) & step_legal(prev_q[11:9], lightM4));
        // Dwell counters hold the yellow samples seen before this one
        short_s    = (((prev_q[2:0] == YELLOW && lightM1 == RED) ||
                       (prev_q[8:6] == YELLOW && lightM3 == RED)) && dwell_a_q < MIN_Y_C) ||
                     (((prev_q[5:3] == YELLOW && lightM2 == RED) ||
                       (prev_q[11:9] == YELLOW && lightM4 == RED)) && dwell_b_q < MIN_Y_C);
        unch_d     = (now_s != prev_q) ? 8'd0 : sat_inc(unch_q);
        stuck_s    = (unch_d == WD_C);
        if (invalid_s) begin
            cause_s = 3'd1;
        end else if (conflict_s) begin
            cause_s = 3'd2;
        end else if (pair_s) begin
            cause_s = 3'd3;
        end else if (primed_q && seq_s) begin
            cause_s = 3'd4;
        end else if (primed_q && short_s) begin
            cause_s = 3'd5;
        end else if (primed_q && stuck_s) begin
            cause_s = 3'd6;
        end else begin
            cause_s = 3'd0;
        end
        latch_s = !clear_fault && !fault_q && (cause_s != 3'd0);
    end

    // Next-state for fault latch, flash divider, dwell counters and history
    always_comb begin
        prev_d    = now_s;
        primed_d  = ~clear_fault;
        fault_d   = fault_q;
        code_d    = code_q;
        flash_d   = flash_q;
        div_d     = div_q;
        dwell_a_d = (lightM1 == YELLOW) ? sat_inc(dwell_a_q) : 8'd0;
        dwell_b_d = (lightM2 == YELLOW) ? sat_inc(dwell_b_q) : 8'd0;
        if (clear_fault) begin
            fault_d   = 1'b0;
            code_d    = 3'd0;
            flash_d   = 1'b0;
            div_d     = 8'd0;
            dwell_a_d = 8'd0;
            dwell_b_d = 8'd0;
        end else if (latch_s) begin
            fault_d = 1'b1;
            code_d  = cause_s;
            flash_d = 1'b1;
            div_d   = 8'd0;
        end else if (fault_q) begin
            if (div_q >= FD_LAST) begin
                flash_d = ~flash_q;
                div_d   = 8'd0;
            end else begin
                div_d = div_q + 8'd1;
            end
        end else begin
            flash_d = 1'b0;
            div_d   = 8'd0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= ALL_RED;
            primed_q  <= 1'b0;
            fault_q   <= 1'b0;
            code_q    <= 3'd0;
            flash_q   <= 1'b0;
            div_q     <= 8'd0;
            dwell_a_q <= 8'd0;
            dwell_b_q <= 8'd0;
            unch_q    <= 8'd0;
        end else begin
            prev_q    <= prev_d;
            primed_q  <= primed_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
            flash_q   <= flash_d;
            div_q     <= div_d;
            dwell_a_q <= dwell_a_d;
            dwell_b_q <= dwell_b_d;
            unch_q    <= clear_fault ? 8'd0 : unch_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign flash      = flash_q;

`ifdef MONITOR_STATS_EN
    logic [15:0] cycle_count_q, cycle_count_d;
    logic [7:0]  fault_count_q, fault_count_d;

    // Statistics next-state: completed light cycles and latch events
    always_comb begin
        if (primed_q && prev_q[2:0] == RED && lightM1 == GREEN) begin
            cycle_count_d = cycle_count_q + 16'd1;
        end else begin
            cycle_count_d = cycle_count_q;
        end
        if (latch_s) begin
            fault_count_d = sat_inc(fault_count_q);
        end else begin
            fault_count_d = fault_count_q;
        end
    end

    // Statistics registers, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count_q <= 16'd0;
            fault_count_q <= 8'd0;
        end else begin
            cycle_count_q <= cycle_count_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign fault_count = fault_count_q;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed scenarios plus a randomized
// controller stream, checked against a history-based reference model.
module tb_traffic_light_monitor;
    localparam int MIN_YELLOW = 4;
    localparam int WATCHDOG   = 16;
    localparam int FLASH_DIV  = 4;
    localparam logic [2:0]  R = 3'b100;
    localparam logic [2:0]  Y = 3'b010;
    localparam logic [2:0]  G = 3'b001;
    localparam logic [11:0] ALL_RED = 12'h924;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] lightM1, lightM2, lightM3, lightM4;
    logic clear_fault;
    logic fault;
    logic [2:0] fault_code;
    logic flash;
`ifdef MONITOR_STATS_EN
    logic [15:0] cycle_count;
    logic [7:0]  fault_count;
`endif

    traffic_light_monitor #(.MIN_YELLOW(MIN_YELLOW), .WATCHDOG(WATCHDOG), .FLASH_DIV(FLASH_DIV)) dut (
        .clk(clk), .rst(rst),
        .lightM1(lightM1), .lightM2(lightM2), .lightM3(lightM3), .lightM4(lightM4),
        .clear_fault(clear_fault), .fault(fault), .fault_code(fault_code),
`ifdef MONITOR_STATS_EN
        .flash(flash), .cycle_count(cycle_count), .fault_count(fault_count)
`else
        .flash(flash)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int f;
        int code;
        int fl;
        int cyc;
        int fcnt;
    } exp_t;

    exp_t exp_q[$];
    logic [11:0] hist[$];
    int seg_start, t_latch, m_code, m_cyc, m_fcnt;
    bit m_fault;
    int total = 0;
    int bad = 0;
    int ph, cnt, g_len, y_len;
    bit rnd_mode;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [2:0] lamp(input logic [11:0] s, input int i);
        return s[3*i +: 3];
    endfunction

    function automatic logic [11:0] sample_at(input int j);
        return (j < 0) ? ALL_RED : hist[j];
    endfunction

    task automatic model_reset();
        hist.delete();
        seg_start = 0;
        m_fault = 1'b0;
        m_code = 0;
        t_latch = 0;
        m_cyc = 0;
        m_fcnt = 0;
    endtask

    // Reference model: rules evaluated over the full sample history
    task automatic model(input logic [11:0] s, input bit clr);
        int k, dw, un, code;
        logic [11:0] p;
        logic [2:0] pl, cl;
        bit primed, c_inv, c_con, c_pair, c_seq, c_sy, yr;
        exp_t e;
        k = hist.size();
        p = sample_at(k - 1);
        primed = (k > seg_start);
        hist.push_back(s);
        c_inv = 1'b0;
        c_seq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cl = lamp(s, i);
            pl = lamp(p, i);
            if (!(cl == R || cl == Y || cl == G)) c_inv = 1'b1;
            if (pl != cl && !((pl == G && cl == Y) || (pl == Y && cl == R) || (pl == R && cl == G)))
                c_seq = 1'b1;
        end
        c_con  = (lamp(s, 0) != R || lamp(s, 2) != R) && (lamp(s, 1) != R || lamp(s, 3) != R);
        c_pair = (lamp(s, 0) != lamp(s, 2)) || (lamp(s, 1) != lamp(s, 3));
        c_sy = 1'b0;
        for (int pr = 0; pr < 2; pr++) begin
            yr = (lamp(p, pr) == Y && lamp(s, pr) == R) || (lamp(p, pr + 2) == Y && lamp(s, pr + 2) == R);
            dw = 0;
            for (int j = k - 1; j >= seg_start && lamp(hist[j], pr) == Y; j--) dw++;
            if (yr && dw < MIN_YELLOW) c_sy = 1'b1;
        end
        un = 0;
        for (int j = k; j >= seg_start && sample_at(j) == sample_at(j - 1); j--) un++;
        code = c_inv ? 1 : c_con ? 2 : c_pair ? 3 : (primed && c_seq) ? 4 :
               (primed && c_sy) ? 5 : (primed && un == WATCHDOG) ? 6 : 0;
        if (primed && lamp(p, 0) == R && lamp(s, 0) == G) m_cyc = (m_cyc + 1) % 65536;
        if (clr) begin
            m_fault = 1'b0;
            m_code = 0;
            seg_start = k + 1;
        end else if (!m_fault && code != 0) begin
            m_fault = 1'b1;
            m_code = code;
            t_latch = k;
            if (m_fcnt < 255) m_fcnt++;
        end
        e.f = int'(m_fault);
        e.code = m_code;
        e.fl = (m_fault && (((k - t_latch) / FLASH_DIV) % 2 == 0)) ? 1 : 0;
        e.cyc = m_cyc;
        e.fcnt = m_fcnt;
        exp_q.push_back(e);
    endtask

    // Drive one sample at a falling edge and queue its expected response
    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                        input logic [2:0] d, input bit clr);
        lightM1 = a;
        lightM2 = b;
        lightM3 = c;
        lightM4 = d;
        clear_fault = clr;
        model({d, c, b, a}, clr);
        @(negedge clk);
        clear_fault = 1'b0;
    endtask

    task automatic legal_step(input bit clr);
        case (ph)
            0:       step(G, R, G, R, clr);
            1:       step(Y, R, Y, R, clr);
            2:       step(R, G, R, G, clr);
            default: step(R, Y, R, Y, clr);
        endcase
        cnt++;
        if (((ph % 2) == 0 && cnt >= g_len) || ((ph % 2) == 1 && cnt >= y_len)) begin
            ph = (ph + 1) % 4;
            cnt = 0;
            if (rnd_mode) begin
                g_len = $urandom_range(5, 20);
                y_len = $urandom_range(2, 6);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ph = 0;
        cnt = 0;
    endtask

    exp_t mon_e;
    // Monitor: pop one expectation per clock and compare just after the edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("fault", int'(fault), mon_e.f);
            check("fault_code", int'(fault_code), mon_e.code);
            check("flash", int'(flash), mon_e.fl);
`ifdef MONITOR_STATS_EN
            check("cycle_count", int'(cycle_count), mon_e.cyc);
            check("fault_count", int'(fault_count), mon_e.fcnt);
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        {lightM1, lightM2, lightM3, lightM4} = {R, R, R, R};
        clear_fault = 1'b0;
        g_len = 11;
        y_len = 4;
        rnd_mode = 1'b0;
        #1;
        check("reset_fault", int'(fault), 0);
        check("reset_code", int'(fault_code), 0);
        check("reset_flash", int'(flash), 0);
        @(negedge clk);
        do_reset();

        // Legal controller stream
        for (int i = 0; i < 200; i++) legal_step(1'b0);
        check("legal_fault", int'(fault), 0);

        // Cross-street conflict and flash cadence
        do_reset();
        step(G, G, G, G, 1'b0);
        check("conflict_code", int'(fault_code), 2);
        check("conflict_flash0", int'(flash), 1);
        for (int i = 0; i < 3; i++) step(G, G, G, G, 1'b0);
        check("conflict_flash3", int'(flash), 1);
        step(G, G, G, G, 1'b0);
        check("conflict_flash4", int'(flash), 0);

        // Short yellow versus full yellow
        do_reset();
        for (int i = 0; i < 3; i++) step(G, R, G, R, 1'b0);
        for (int i = 0; i < 2; i++) step(Y, R, Y, R, 1'b0);
        step(R, R, R, R, 1'b0);
        check("short_y_code", int'(fault_code), 5);
        do_reset();
        for (int i = 0; i < 3; i++) step(G, R, G, R, 1'b0);
        for (int i = 0; i < 4; i++) step(Y, R, Y, R, 1'b0);
        step(R, R, R, R, 1'b0);
        step(R, G, R, G, 1'b0);
        check("full_y_fault", int'(fault), 0);

        // Green straight to red, and the same with an invalid code
        do_reset();
        for (int i = 0; i < 3; i++) step(G, R, G, R, 1'b0);
        step(R, R, R, R, 1'b0);
        check("seq_code", int'(fault_code), 4);
        do_reset();
        for (int i = 0; i < 3; i++) step(G, R, G, R, 1'b0);
        step(R, 3'b011, R, R, 1'b0);
        check("invalid_code", int'(fault_code), 1);

        // Stuck pattern, clear, re-detection, then asynchronous reset while flashing
        do_reset();
        for (int i = 0; i < 16; i++) step(G, R, G, R, 1'b0);
        check("stuck_early", int'(fault), 0);
        step(G, R, G, R, 1'b0);
        check("stuck_code", int'(fault_code), 6);
        for (int i = 0; i < 3; i++) step(G, R, G, R, 1'b0);
        step(G, R, G, R, 1'b1);
        check("clear_fault", int'(fault), 0);
        check("clear_flash", int'(flash), 0);
        for (int i = 0; i < 15; i++) step(G, R, G, R, 1'b0);
        check("restuck_early", int'(fault), 0);
        step(G, R, G, R, 1'b0);
        check("restuck_code", int'(fault_code), 6);
        for (int i = 0; i < 8; i++) step(G, R, G, R, 1'b0);
        check("flash_before_rst", int'(flash), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_fault", int'(fault), 0);
        check("async_code", int'(fault_code), 0);
        check("async_flash", int'(flash), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ph = 0;
        cnt = 0;

`ifdef MONITOR_STATS_EN
        for (int i = 0; i < 91; i++) legal_step(1'b0);
        check("stats_cycles", int'(cycle_count), 3);
        do_reset();
`endif

        // Randomized controller stream with glitches, odd timings and clears
        rnd_mode = 1'b1;
        g_len = $urandom_range(5, 20);
        y_len = $urandom_range(2, 6);
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (m_fault && r < 10) begin
                legal_step(1'b1);
            end else if (r < 13) begin
                step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
            end else begin
                legal_step(1'b0);
            end
        end

        @(negedge clk);
        @(negedge clk);
        check("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
